// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares the single write port of a FIFO between NUM_REQ producers. Each
// producer streams beats with a valid/ready handshake. Ownership is granted
// round-robin and held for a whole burst. A burst ends on an accepted beat
// flagged req_last, or on the MAX_BURST-th accepted beat, whichever comes
// first. The FIFO full flag stalls the owner without losing or repeating a
// beat. Every grant starts with one arbitration cycle in which no beat is
// accepted.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   req_valid     per-requester beat valid
//   req_data      beats; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last      per-requester last-beat flag, qualified by valid
//   req_ready     per-requester ready; a beat is taken when valid & ready
//   fifo_full     FIFO full flag
//   fifo_wren     FIFO write enable
//   fifo_data     FIFO write data (zero when not writing)
//   grant_id      index of the current owner, meaningful while grant_active
//   grant_active  high while a burst is owned
//   burst_cnt     beats accepted so far in the current burst
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wren,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [IDW-1:0]                grant_id,
    output logic                          grant_active,
    output logic [7:0]                    burst_cnt
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  port_open;
    logic                  accept;
    logic                  burst_end;
    logic                  found;
    logic [IDW-1:0]        winner;
    logic [IDW:0]          scan_sum;
    logic [IDW-1:0]        next_ptr;

    // Mux out the owner's valid/last/data; every other requester is ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign port_open = (state_q == BURST) && !fifo_full;
    assign accept    = port_open && sel_valid;
    assign fifo_wren = accept;
    assign fifo_data = accept ? sel_data : '0;

    // A last beat landing on the MAX_BURST-th beat is a single end event.
    assign burst_end = accept && (sel_last || (burst_cnt_q == 8'(MAX_BURST - 1)));

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = port_open && (grant_id_q == IDW'(i));
        end
    end

    // Round-robin scan starting at rr_ptr; the sum is one bit wider so the
    // wrap back to zero can be detected without overflow.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan_sum[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan_sum[IDW-1:0];
            end
        end
    end

    assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    grant_id_d  = winner;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                // rr_ptr only moves past the owner once its burst is over.
                if (burst_end) begin
                    state_d     = ARB;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == BURST);
    assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Scoreboard bench for fifo_write_arbiter with NUM_REQ=4, DATA_WIDTH=8 and
// MAX_BURST=4. Each requester owns a beat list that a driver presents one
// beat at a time. The expected FIFO writes (owner, data, burst count) are
// queued in hand-computed grant order as each scenario is issued. A monitor
// on the falling edge pops one entry for every fifo_wren and compares it.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wren;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        grant_id;
    logic              grant_active;
    logic [7:0]        burst_cnt;

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wren    (fifo_wren),
        .fifo_data    (fifo_data),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .burst_cnt    (burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic [7:0] cnt;
    } expBeat_t;

    expBeat_t   expQ[$];
    expBeat_t   expHead;
    logic [7:0] beatData[NR][64];
    logic       beatLast[NR][64];
    int         headIdx[NR];
    int         tailIdx[NR];
    logic       gap[NR];
    logic [NR-1:0] acceptSeen;
    int         checks = 0;
    int         errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic addBeat(input int id, input logic [7:0] d, input logic l);
        beatData[id][tailIdx[id]] = d;
        beatLast[id][tailIdx[id]] = l;
        tailIdx[id]++;
    endtask

    task automatic expectBeat(input int id, input logic [7:0] d, input int cnt);
        expQ.push_back({2'(id), d, 8'(cnt)});
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) begin
            if (headIdx[i] != tailIdx[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: retire beats accepted on the last edge, present the next.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acceptSeen[i] && headIdx[i] != tailIdx[i]) headIdx[i]++;
            if (headIdx[i] != tailIdx[i] && !gap[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = beatData[i][headIdx[i]];
                req_last[i]           = beatLast[i][headIdx[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
        #1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || pending()) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({name, " drained"}, 32'((expQ.size() == 0) && !pending()), 32'd1);
    endtask

    // Monitor: inputs are stable by the falling edge, so valid & ready here
    // is exactly what the DUT takes on the next rising edge.
    always @(negedge clk) begin
        acceptSeen = req_valid & req_ready;
        if (!reset && fifo_wren) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected write: got data %0h id %0d, expected no write",
                         fifo_data, grant_id);
            end else begin
                expHead = expQ.pop_front();
                if (fifo_data !== expHead.data || grant_id !== expHead.id ||
                    burst_cnt !== expHead.cnt) begin
                    errors++;
                    $display("[TB] FAIL write: got id %0d data %0h cnt %0d expected id %0d data %0h cnt %0d",
                             grant_id, fifo_data, burst_cnt, expHead.id, expHead.data, expHead.cnt);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            headIdx[i] = 0;
            tailIdx[i] = 0;
            gap[i]     = 1'b0;
        end
        fifo_full = 1'b0;
        req_valid = '1;
        req_data  = 32'hDEADBEEF;
        req_last  = '1;

        // Reset state: even with every requester valid nothing is granted.
        #1;
        checkOutput("reset grant_active", 32'(grant_active), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset fifo_wren", 32'(fifo_wren), 32'd0);
        checkOutput("reset fifo_data", 32'(fifo_data), 32'd0);
        checkOutput("reset burst_cnt", 32'(burst_cnt), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single requester: one ARB cycle, then three writes in order.
        addBeat(1, 8'hA1, 1'b0);
        addBeat(1, 8'hA2, 1'b0);
        addBeat(1, 8'hA3, 1'b1);
        expectBeat(1, 8'hA1, 0);
        expectBeat(1, 8'hA2, 1);
        expectBeat(1, 8'hA3, 2);
        applyStimulus();
        checkOutput("t1 arb grant_active", 32'(grant_active), 32'd0);
        checkOutput("t1 arb fifo_wren", 32'(fifo_wren), 32'd0);
        applyStimulus();
        checkOutput("t1 grant_active", 32'(grant_active), 32'd1);
        checkOutput("t1 grant_id", 32'(grant_id), 32'd1);
        checkOutput("t1 req_ready", 32'(req_ready), 32'b0010);
        checkOutput("t1 fifo_wren", 32'(fifo_wren), 32'd1);
        waitDrain("t1", 20);
        checkOutput("t1 back to arb", 32'(grant_active), 32'd0);

        // Round-robin, all four continuously valid with 2-beat bursts.
        // rr_ptr was left at 2 by the previous burst from requester 1.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NR; i++) begin
                addBeat(i, 8'(i*16 + b*2), 1'b0);
                addBeat(i, 8'(i*16 + b*2 + 1), 1'b1);
            end
        end
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < NR; j++) begin
                expectBeat((2 + j) % NR, 8'(((2 + j) % NR)*16 + b*2), 0);
                expectBeat((2 + j) % NR, 8'(((2 + j) % NR)*16 + b*2 + 1), 1);
            end
        end
        waitDrain("t2", 100);

        // MAX_BURST cap: req0 streams 10 beats, last only on the tenth.
        // rr_ptr=2, so req3 goes first, req1 slips in after req0's first cap.
        addBeat(3, 8'hE3, 1'b1);
        addBeat(1, 8'hE1, 1'b1);
        for (int k = 0; k < 10; k++) addBeat(0, 8'(8'hC0 + k), 1'(k == 9));
        expectBeat(3, 8'hE3, 0);
        for (int k = 0; k < 4; k++) expectBeat(0, 8'(8'hC0 + k), k);
        expectBeat(1, 8'hE1, 0);
        for (int k = 4; k < 8; k++) expectBeat(0, 8'(8'hC0 + k), k - 4);
        expectBeat(0, 8'hC8, 0);
        expectBeat(0, 8'hC9, 1);
        waitDrain("t3", 100);

        // Backpressure: 5 full cycles mid-burst, then full on the last beat,
        // which also lands on the MAX_BURST-th beat. rr_ptr=1 -> req2.
        for (int k = 0; k < 4; k++) addBeat(2, 8'(8'h50 + k), 1'(k == 3));
        for (int k = 0; k < 4; k++) expectBeat(2, 8'(8'h50 + k), k);
        applyStimulus();
        repeat (3) applyStimulus();
        fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t4 stall fifo_wren", 32'(fifo_wren), 32'd0);
            checkOutput("t4 stall req_ready", 32'(req_ready), 32'd0);
            checkOutput("t4 stall burst_cnt", 32'(burst_cnt), 32'd2);
            checkOutput("t4 stall grant_active", 32'(grant_active), 32'd1);
            applyStimulus();
        end
        fifo_full = 1'b0;
        #1;
        checkOutput("t4 resume fifo_wren", 32'(fifo_wren), 32'd1);
        checkOutput("t4 resume burst_cnt", 32'(burst_cnt), 32'd2);
        applyStimulus();
        fifo_full = 1'b1;
        #1;
        checkOutput("t4 full on last fifo_wren", 32'(fifo_wren), 32'd0);
        checkOutput("t4 full on last burst_cnt", 32'(burst_cnt), 32'd3);
        applyStimulus();
        fifo_full = 1'b0;
        #1;
        checkOutput("t4 last resumes fifo_wren", 32'(fifo_wren), 32'd1);
        waitDrain("t4", 20);
        checkOutput("t4 single end event", 32'(grant_active), 32'd0);

        // Owner idle gap: req3 drops valid for 3 cycles while 0 and 1 wait.
        addBeat(3, 8'h70, 1'b0);
        addBeat(3, 8'h71, 1'b0);
        addBeat(3, 8'h72, 1'b1);
        addBeat(0, 8'h80, 1'b1);
        addBeat(1, 8'h90, 1'b1);
        expectBeat(3, 8'h70, 0);
        expectBeat(3, 8'h71, 1);
        expectBeat(3, 8'h72, 2);
        expectBeat(0, 8'h80, 0);
        expectBeat(1, 8'h90, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("t5 grant_id", 32'(grant_id), 32'd3);
        gap[3] = 1'b1;
        repeat (3) begin
            applyStimulus();
            checkOutput("t5 gap grant_active", 32'(grant_active), 32'd1);
            checkOutput("t5 gap grant_id", 32'(grant_id), 32'd3);
            checkOutput("t5 gap fifo_wren", 32'(fifo_wren), 32'd0);
            checkOutput("t5 gap burst_cnt", 32'(burst_cnt), 32'd1);
        end
        gap[3] = 1'b0;
        waitDrain("t5", 30);

        // Reset mid-burst: rr_ptr=2 -> req2, reset lands between edges
        // while beat 2 is on offer.
        addBeat(2, 8'h60, 1'b0);
        addBeat(2, 8'h61, 1'b0);
        addBeat(2, 8'h62, 1'b1);
        expectBeat(2, 8'h60, 0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t6 pre-reset burst_cnt", 32'(burst_cnt), 32'd1);
        checkOutput("t6 pre-reset fifo_wren", 32'(fifo_wren), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t6 reset grant_active", 32'(grant_active), 32'd0);
        checkOutput("t6 reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("t6 reset fifo_wren", 32'(fifo_wren), 32'd0);
        checkOutput("t6 reset burst_cnt", 32'(burst_cnt), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            headIdx[i] = 0;
            tailIdx[i] = 0;
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        // rr_ptr is back at 0, so req1 must beat req3.
        addBeat(3, 8'hB3, 1'b1);
        addBeat(1, 8'hB1, 1'b1);
        expectBeat(1, 8'hB1, 0);
        expectBeat(3, 8'hB3, 0);
        waitDrain("t6", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin, burst-locked arbiter that shares the single write port of the FIFO between NUM_REQ independent producers. Each producer uses a valid/ready handshake. The block drives the FIFO WREN/data_in pair directly and honours the FIFO full flag, so no beat is ever dropped or duplicated. A grant is held for one burst, which ends on req_last or after MAX_BURST beats.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, beat width; matches the FIFO data_width
MAX_BURST, 16, maximum beats per grant (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-requester last beat of burst; qualified by valid
req_ready  output  NUM_REQ  per-requester beat accepted this cycle when valid&ready
fifo_full  input  1  FIFO full flag
fifo_wren  output  1  FIFO write enable
fifo_data  output  DATA_WIDTH  FIFO write data
grant_id  output  clog2(NUM_REQ)  index of the current owner; valid while grant_active
grant_active  output  1  high in BURST state
burst_cnt  output  8  beats accepted in the current burst

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-high. It may assert at any cycle, including mid-burst.
- Reset values: state=ARB, rr_ptr=0, grant_id=0, burst_cnt=0, grant_active=0. With state forced to ARB, req_ready=0, fifo_wren=0 and fifo_data=0.
- Registered state: state (ARB, BURST), rr_ptr, grant_id, burst_cnt.
- Combinational outputs (zero added latency):
  - req_ready[i] = (state==BURST) && (grant_id==i) && !fifo_full
  - accept = req_valid[grant_id] && req_ready[grant_id]
  - fifo_wren = accept
  - fifo_data = accept ? slice(grant_id) : 0
- ARB state:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set index wins.
  - If a winner exists: grant_id<=winner, burst_cnt<=0, state<=BURST on the next edge.
  - No beat is accepted in ARB, so arbitration costs exactly one cycle.
  - If no requester is valid, stay in ARB.
- BURST state:
  - On each accept, burst_cnt increments.
  - The burst ends on an accepted beat with req_last[grant_id]=1, or on the accepted beat that makes burst_cnt+1==MAX_BURST.
  - At burst end: state<=ARB, rr_ptr<=(grant_id+1) mod NUM_REQ, burst_cnt<=0.
- Stalls:
  - fifo_full=1 forces req_ready=0 and fifo_wren=0. State and counters hold. There is no timeout.
  - The owner deasserting valid mid-burst also holds state. The grant is not released until last or MAX_BURST.
- Fairness: rr_ptr advances only past the owner. A continuously-valid requester waits at most NUM_REQ-1 bursts.
- Non-owners always see req_ready=0. Their valid, data and last inputs are ignored.
- Beat ordering: beats from one requester reach the FIFO in order, with no interleaving inside a burst.
- Boundary cases:
  - MAX_BURST=1 ends every burst after one beat.
  - A last beat at burst_cnt==MAX_BURST-1 is one end event, not two.
  - fifo_full rising the same cycle as a last beat blocks that beat; it completes later.
  - Counter width is 8 bits; MAX_BURST ≤ 255 is guaranteed, so burst_cnt does not wrap.
- Reset mid-burst aborts the burst. A requester must re-present its burst from the start after reset.

Test Plan:
- Single requester: NUM_REQ=4; req1 sends 3 beats 0xA1,0xA2,0xA3 with last on beat 3.
  - Expect one ARB cycle, then fifo_wren high 3 cycles with data in order.
  - grant_id=1 throughout; afterwards rr_ptr=2 and state=ARB.
- Round-robin: all 4 requesters continuously valid with 2-beat bursts.
  - Expect grant order 0,1,2,3,0,…
  - Each burst is 2 write cycles followed by 1 ARB cycle; no requester is skipped.
- MAX_BURST cap: MAX_BURST=4; req0 valid for 10 beats with no last.
  - Expect writes of 4 beats, then an ARB cycle, then the next requester if one is valid.
  - If no other requester is valid, req0 is re-granted.
  - burst_cnt sequence is 0,1,2,3,0.
- Full backpressure: fifo_full=1 for 5 cycles mid-burst while the owner holds valid.
  - Expect req_ready=0 and fifo_wren=0 during the stall, with burst_cnt frozen.
  - Writing resumes the cycle after fifo_full falls, with no lost or duplicated beat (scoreboard against the data sequence).
- Owner idle gap: owner drops valid for 3 cycles mid-burst while others are valid.
  - Expect the grant to be held with no writes; the burst resumes and ends on last.
  - Only then does rr_ptr advance.
- Reset mid-burst: assert reset asynchronously between edges during beat 2 of a burst.
  - Expect grant_active, req_ready and fifo_wren to drop immediately, and burst_cnt=0 and rr_ptr=0.
  - After deassertion, arbitration restarts from index 0.
